// File: rtl/data_sram_resp_if.sv
// Data-SRAM request/response bundle between the execute-stage requester and the responder.
interface data_sram_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: byte-writable word RAM plus a small MMIO block (timer/IRQ, LED, scratch).
// One access per cycle; read data is registered and appears the cycle after en.
module data_sram_resp #(
    parameter int          RAM_AW  = 14,
    parameter logic [15:0] MMIO_HI = 16'hBFAF,
    parameter int          LED_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    data_sram_resp_if.slave  bus,
    output logic [LED_W-1:0] led_out,
    output logic             timer_irq,
    output logic             err_flag
);

    localparam logic [15:0] OFF_TIMER   = 16'h0000;
    localparam logic [15:0] OFF_TCMP    = 16'h0004;
    localparam logic [15:0] OFF_TCTRL   = 16'h0008;
    localparam logic [15:0] OFF_LED     = 16'h000C;
    localparam logic [15:0] OFF_SCRATCH = 16'h0010;

    logic [31:0] mem [2**RAM_AW];

    logic [31:0] timer;
    logic [31:0] tcmp;
    logic        irq_en;
    logic [31:0] scratch;

    logic              en;
    logic [3:0]        wen;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              mmio_sel;
    logic [15:0]       off;
    logic [RAM_AW-1:0] ram_idx;
    logic              full_wen;
    logic              hit_timer, hit_tcmp, hit_tctrl, hit_led, hit_scratch, off_valid;
    logic              mmio_wr, mmio_bad;
    logic              wr_timer, wr_tcmp, wr_tctrl, wr_led, wr_scratch;
    logic              ram_wr;
    logic              irq_set, irq_clr;
    logic [31:0]       mmio_rd;

    assign en    = bus.data_sram_en;
    assign wen   = bus.data_sram_wen;
    assign addr  = bus.data_sram_addr;
    assign wdata = bus.data_sram_wdata;

    always_comb begin
        mmio_sel    = (addr[31:16] == MMIO_HI);
        off         = addr[15:0];
        ram_idx     = addr[RAM_AW+1:2];
        full_wen    = (wen == 4'b1111);

        hit_timer   = (off == OFF_TIMER);
        hit_tcmp    = (off == OFF_TCMP);
        hit_tctrl   = (off == OFF_TCTRL);
        hit_led     = (off == OFF_LED);
        hit_scratch = (off == OFF_SCRATCH);
        off_valid   = hit_timer | hit_tcmp | hit_tctrl | hit_led | hit_scratch;

        // MMIO registers only accept whole-word writes; anything else is flagged.
        mmio_wr     = en && mmio_sel && full_wen;
        mmio_bad    = en && mmio_sel && (wen != 4'b0000) && (!full_wen || !off_valid);
        wr_timer    = mmio_wr && hit_timer;
        wr_tcmp     = mmio_wr && hit_tcmp;
        wr_tctrl    = mmio_wr && hit_tctrl;
        wr_led      = mmio_wr && hit_led;
        wr_scratch  = mmio_wr && hit_scratch;

        ram_wr      = en && !mmio_sel && (wen != 4'b0000) && !reset;

        // Compare against the pre-increment count; a same-cycle clear loses to a set.
        irq_set     = irq_en && (timer == tcmp);
        irq_clr     = wr_tctrl && wdata[1];

        mmio_rd = 32'h0;
        unique case (1'b1)
            hit_timer:   mmio_rd = timer;
            hit_tcmp:    mmio_rd = tcmp;
            hit_tctrl:   mmio_rd = {31'h0, irq_en};
            hit_led:     mmio_rd = 32'(led_out);
            hit_scratch: mmio_rd = scratch;
            default:     mmio_rd = 32'h0;
        endcase
    end

    // RAM array has no reset; writes are byte-masked.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wen[b]) mem[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Read-first: both sources are sampled before this edge's writes land.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.data_sram_rdata <= 32'h0;
        end else if (en) begin
            bus.data_sram_rdata <= mmio_sel ? mmio_rd : mem[ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer     <= 32'h0;
            tcmp      <= 32'hFFFF_FFFF;
            irq_en    <= 1'b0;
            led_out   <= '0;
            scratch   <= 32'h0;
            timer_irq <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            timer     <= wr_timer ? wdata : timer + 32'd1;
            if (wr_tcmp)    tcmp    <= wdata;
            if (wr_tctrl)   irq_en  <= wdata[0];
            if (wr_led)     led_out <= wdata[LED_W-1:0];
            if (wr_scratch) scratch <= wdata;
            timer_irq <= irq_set | (timer_irq & ~irq_clr);
            if (mmio_bad)   err_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Randomized and directed checks of data_sram_resp against a transaction-level reference model.
module tb_data_sram_resp;

    localparam logic [31:0] MM = 32'hBFAF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] led_out;
    logic        timer_irq;
    logic        err_flag;

    int errors = 0;
    int checks = 0;

    data_sram_resp_if bus();

    data_sram_resp #(.RAM_AW(14), .MMIO_HI(16'hBFAF), .LED_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .led_out   (led_out),
        .timer_irq (timer_irq),
        .err_flag  (err_flag)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_ram [int];
    logic [31:0] m_rdata;
    bit          m_known;
    logic [31:0] m_timer, m_tcmp, m_scratch;
    logic [15:0] m_led;
    bit          m_irq_en, m_irq, m_err;

    function automatic logic [31:0] m_read(input logic [15:0] off);
        case (off)
            16'h0000: return m_timer;
            16'h0004: return m_tcmp;
            16'h0008: return {31'h0, m_irq_en};
            16'h000C: return {16'h0, m_led};
            16'h0010: return m_scratch;
            default:  return 32'h0;
        endcase
    endfunction

    // Drive one cycle at the falling edge, advance the model, sample just after the rising edge.
    task automatic step(input bit rst, input bit en, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata);
        bit          set, clr, valid;
        logic [31:0] t_next, w;
        int          idx;
        @(negedge clk);
        reset = rst;
        bus.data_sram_en = en;  bus.data_sram_wen = wen;
        bus.data_sram_addr = addr;  bus.data_sram_wdata = wdata;
        if (rst) begin
            m_rdata = 0; m_known = 1; m_timer = 0; m_tcmp = 32'hFFFF_FFFF;
            m_irq_en = 0; m_irq = 0; m_err = 0; m_led = 0; m_scratch = 0;
        end else begin
            set = m_irq_en && (m_timer == m_tcmp);
            clr = 0;
            t_next = m_timer + 1;
            if (en && addr[31:16] == 16'hBFAF) begin
                m_rdata = m_read(addr[15:0]);
                m_known = 1;
                valid = addr[15:0] inside {16'h0, 16'h4, 16'h8, 16'hC, 16'h10};
                if (wen != 0 && (wen != 4'hF || !valid)) m_err = 1;
                else if (wen == 4'hF) begin
                    case (addr[15:0])
                        16'h0000: t_next = wdata;
                        16'h0004: m_tcmp = wdata;
                        16'h0008: begin m_irq_en = wdata[0]; clr = wdata[1]; end
                        16'h000C: m_led = wdata[15:0];
                        default:  m_scratch = wdata;
                    endcase
                end
            end else if (en) begin
                idx = int'(addr[15:2]);
                m_known = m_ram.exists(idx);
                if (m_known) m_rdata = m_ram[idx];
                if (wen == 4'hF) m_ram[idx] = wdata;
                else if (wen != 0 && m_ram.exists(idx)) begin
                    w = m_ram[idx];
                    for (int b = 0; b < 4; b++) if (wen[b]) w[8*b +: 8] = wdata[8*b +: 8];
                    m_ram[idx] = w;
                end
            end
            m_timer = t_next;
            m_irq = set | (m_irq & ~clr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        step(1, 0, 4'h0, 32'h0, 32'h0);
        step(1, 0, 4'h0, 32'h0, 32'h0);
        checks++;
        if (bus.data_sram_rdata !== 32'h0 || led_out !== 16'h0 || timer_irq !== 1'b0 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdata=%h led=%h irq=%b err=%b, required 0/0/0/0",
                     bus.data_sram_rdata, led_out, timer_irq, err_flag);
        end
        step(0, 1, 4'h0, MM + 32'h4, 32'h0);
        checks++;
        if (bus.data_sram_rdata !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_tcmp: got %h, required ffffffff", bus.data_sram_rdata);
        end
        step(0, 1, 4'h0, MM + 32'h0, 32'h0);
        checks++;
        if (bus.data_sram_rdata !== m_rdata) begin
            errors++;
            $display("FAIL reset_timer: got %h, required %h", bus.data_sram_rdata, m_rdata);
        end
    endtask

    task automatic test_ram_bytes();
        step(0, 1, 4'hF, 32'h100, 32'h1122_3344);
        step(0, 1, 4'b0010, 32'h100, 32'hAAAA_AAAA);
        step(0, 1, 4'h0, 32'h100, 32'h0);
        checks++;
        if (bus.data_sram_rdata !== 32'h1122_AA44) begin
            errors++;
            $display("FAIL ram_bytes: got %h, required 1122aa44", bus.data_sram_rdata);
        end
        idle();
        checks++;
        if (bus.data_sram_rdata !== 32'h1122_AA44) begin
            errors++;
            $display("FAIL rdata_hold: got %h, required 1122aa44", bus.data_sram_rdata);
        end
        step(0, 0, 4'hF, 32'h100, 32'h0);
        step(0, 1, 4'h0, 32'h100, 32'h0);
        checks++;
        if (bus.data_sram_rdata !== 32'h1122_AA44) begin
            errors++;
            $display("FAIL wen_without_en: got %h, required 1122aa44", bus.data_sram_rdata);
        end
    endtask

    task automatic test_read_first();
        step(0, 1, 4'hF, 32'h200, 32'h5);
        step(0, 1, 4'hF, 32'h200, 32'h9);
        checks++;
        if (bus.data_sram_rdata !== 32'h5) begin
            errors++;
            $display("FAIL read_first_old: got %h, required 5", bus.data_sram_rdata);
        end
        step(0, 1, 4'h0, 32'h200, 32'h0);
        checks++;
        if (bus.data_sram_rdata !== 32'h9) begin
            errors++;
            $display("FAIL read_first_new: got %h, required 9", bus.data_sram_rdata);
        end
    endtask

    task automatic test_timer_irq();
        int rise = -1;
        step(1, 0, 4'h0, 32'h0, 32'h0);
        step(0, 1, 4'hF, MM + 32'h4, 32'd20);
        step(0, 1, 4'hF, MM + 32'h8, 32'd1);
        for (int c = 3; c <= 40; c++) begin
            idle();
            checks++;
            if (timer_irq !== m_irq) begin
                errors++;
                $display("FAIL irq_track cyc%0d: got %b, required %b", c, timer_irq, m_irq);
            end
            if (rise < 0 && timer_irq === 1'b1) rise = c;
        end
        // Timer pre-value in post-reset cycle c is c-1, so it equals 20 in cycle 21.
        checks++;
        if (rise != 21) begin
            errors++;
            $display("FAIL irq_rise_cycle: got %0d, required 21", rise);
        end
        step(0, 1, 4'hF, MM + 32'h8, 32'd3);
        checks++;
        if (timer_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: got %b, required 0", timer_irq);
        end
        step(0, 1, 4'h0, MM + 32'h8, 32'h0);
        checks++;
        if (bus.data_sram_rdata !== 32'h1) begin
            errors++;
            $display("FAIL tctrl_readback: got %h, required 1", bus.data_sram_rdata);
        end
    endtask

    task automatic test_timer_wrap();
        logic [31:0] exp [3];
        exp[0] = 32'hFFFF_FFFE; exp[1] = 32'hFFFF_FFFF; exp[2] = 32'h0;
        step(0, 1, 4'hF, MM, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 4'h0, MM, 32'h0);
            checks++;
            if (bus.data_sram_rdata !== exp[i]) begin
                errors++;
                $display("FAIL timer_wrap[%0d]: got %h, required %h", i, bus.data_sram_rdata, exp[i]);
            end
        end
    endtask

    task automatic test_illegal();
        step(0, 1, 4'hF, MM + 32'hC, 32'h0000_1234);
        checks++;
        if (led_out !== 16'h1234 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL led_write: led=%h err=%b, required 1234/0", led_out, err_flag);
        end
        step(0, 1, 4'b0011, MM + 32'hC, 32'hFFFF_FFFF);
        checks++;
        if (led_out !== 16'h1234 || err_flag !== 1'b1) begin
            errors++;
            $display("FAIL led_partial: led=%h err=%b, required 1234/1", led_out, err_flag);
        end
        step(0, 1, 4'hF, MM + 32'h20, 32'h5555_5555);
        step(0, 1, 4'h0, MM + 32'h20, 32'h0);
        checks++;
        if (bus.data_sram_rdata !== 32'h0 || err_flag !== 1'b1) begin
            errors++;
            $display("FAIL bad_offset: rdata=%h err=%b, required 0/1", bus.data_sram_rdata, err_flag);
        end
    endtask

    task automatic test_reset_midop();
        step(0, 1, 4'hF, 32'h300, 32'h1234_5678);
        step(0, 1, 4'hF, MM + 32'h10, 32'hCAFE_F00D);
        step(1, 1, 4'hF, 32'h300, 32'h0000_DEAD);
        checks++;
        if (bus.data_sram_rdata !== 32'h0 || led_out !== 16'h0 || timer_irq !== 1'b0 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL midop_outputs: rdata=%h led=%h irq=%b err=%b, required 0/0/0/0",
                     bus.data_sram_rdata, led_out, timer_irq, err_flag);
        end
        step(0, 1, 4'h0, 32'h300, 32'h0);
        checks++;
        if (bus.data_sram_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL midop_ram: got %h, required 12345678", bus.data_sram_rdata);
        end
        step(0, 1, 4'h0, MM + 32'h10, 32'h0);
        checks++;
        if (bus.data_sram_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midop_scratch: got %h, required 0", bus.data_sram_rdata);
        end
    endtask

    task automatic test_random();
        logic [15:0] offs [6];
        logic [31:0] a;
        logic [15:0] hi;
        offs[0] = 16'h0; offs[1] = 16'h4; offs[2] = 16'h8;
        offs[3] = 16'hC; offs[4] = 16'h10; offs[5] = 16'h20;
        for (int i = 0; i < 16; i++) step(0, 1, 4'hF, 32'h400 + 32'(4 * i), $urandom);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = MM + 32'(offs[$urandom_range(0, 5)]);
            end else begin
                // Alias through random upper bits, avoiding the MMIO window.
                hi = 16'($urandom);
                if (hi == 16'hBFAF) hi = 16'h0;
                a = {hi, 16'h0400 + 16'(4 * $urandom_range(0, 15))};
            end
            step(0, $urandom_range(0, 4) != 0, 4'($urandom), a, $urandom);
            checks++;
            if ((m_known && bus.data_sram_rdata !== m_rdata) || led_out !== m_led ||
                timer_irq !== m_irq || err_flag !== m_err) begin
                errors++;
                $display("FAIL random[%0d]: rdata=%h led=%h irq=%b err=%b, required %h/%h/%b/%b",
                         n, bus.data_sram_rdata, led_out, timer_irq, err_flag,
                         m_rdata, m_led, m_irq, m_err);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.data_sram_en = 1'b0; bus.data_sram_wen = 4'h0;
        bus.data_sram_addr = 32'h0; bus.data_sram_wdata = 32'h0;
        test_reset();
        test_ram_bytes();
        test_read_first();
        test_timer_irq();
        test_timer_wrap();
        test_illegal();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
